// File: rtl/alu_writeback.sv
// ---------------------------------------------------------------------------
// alu_writeback
//
// Writeback sequencer at the consuming end of the ALU result interface.
// Accepts an ALU result (Out, R, signFlag) tagged with its op code and
// destination register, and writes it into the register file.
//
// Multiply (3'b010) and divide (3'b011) return two results. Out goes to the
// held destination in one cycle and R goes to REM_REG in the next. While Out
// is being written, in_ready is held low for that single cycle.
//
// Z/N status flags and a wrapping count of accepted results are also kept
// here.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous reset, active-low
//   in_valid   ALU result valid this cycle
//   in_ready   block can accept a result this cycle
//   in_op      op code the result came from
//   in_dest    destination register
//   in_out     ALU Out
//   in_r       ALU R (high product / remainder)
//   in_sign    ALU signFlag
//   rf_we      register file write enable
//   rf_waddr   register file write address
//   rf_wdata   register file write data
//   flag_z     zero flag
//   flag_n     negative flag
//   retired    count of accepted results (wraps)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no pending write
// WB_LO | write held Out to held destination
// WB_HI | write held R to REM_REG (second half of multiply/divide)
// ---------------------------------------------------------------------------
module alu_writeback #(
   parameter logic [3:0] REM_REG = 4'd15,
   parameter int         CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic [3:0]       in_dest,
   input  logic [15:0]      in_out,
   input  logic [15:0]      in_r,
   input  logic             in_sign,
   output logic             rf_we,
   output logic [3:0]       rf_waddr,
   output logic [15:0]      rf_wdata,
   output logic             flag_z,
   output logic             flag_n,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WB_LO = 2'd1,
      WB_HI = 2'd2
   } state_t;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_MUL  = 3'b010;
   localparam logic [2:0] OP_DIV  = 3'b011;
   localparam logic [2:0] OP_NOWB = 3'b111;

   state_t      state_q;
   state_t      state_d;

   logic [2:0]  op_q;
   logic [3:0]  dest_q;
   logic [15:0] out_q;
   logic [15:0] r_q;
   logic        sign_q;

   logic        held_two;
   logic        xfer;

   logic        flag_upd;
   logic        flag_z_d;
   logic        flag_n_d;

   // in_ready depends only on registered state and the held op, so it never
   // loops back combinationally through in_valid.
   assign held_two = (op_q == OP_MUL) || (op_q == OP_DIV);
   assign in_ready = !((state_q == WB_LO) && held_two);
   assign xfer     = in_valid && in_ready;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state and Moore outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      rf_we    = 1'b0;
      rf_waddr = 4'd0;
      rf_wdata = 16'd0;

      case (state_q)
         IDLE: begin
            if (xfer) begin
               state_d = WB_LO;
            end
         end

         WB_LO: begin
            rf_waddr = dest_q;
            rf_wdata = out_q;
            // R0 is hardwired; op 111 produces no register result.
            rf_we    = (op_q != OP_NOWB) && (dest_q != 4'd0);
            if (held_two) begin
               state_d = WB_HI;
            end else if (xfer) begin
               state_d = WB_LO;
            end else begin
               state_d = IDLE;
            end
         end

         WB_HI: begin
            rf_waddr = REM_REG;
            rf_wdata = r_q;
            rf_we    = 1'b1;
            if (xfer) begin
               state_d = WB_LO;
            end else begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Holding registers: loaded on every transfer. A two-result op cannot be
   // overwritten before its R write because in_ready is low in its WB_LO.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q   <= 3'd0;
         dest_q <= 4'd0;
         out_q  <= 16'd0;
         r_q    <= 16'd0;
         sign_q <= 1'b0;
      end else if (xfer) begin
         op_q   <= in_op;
         dest_q <= in_dest;
         out_q  <= in_out;
         r_q    <= in_r;
         sign_q <= in_sign;
      end
   end

   // ------------------------------------------------------------------
   // Status flags: computed from the held result and committed on the edge
   // that leaves WB_LO. Multiply looks at the full 32-bit product.
   // ------------------------------------------------------------------
   always_comb begin
      flag_upd = 1'b0;
      flag_z_d = flag_z;
      flag_n_d = flag_n;
      if ((state_q == WB_LO) && sign_q) begin
         case (op_q)
            OP_ADD, OP_SUB, OP_DIV: begin
               flag_upd = 1'b1;
               flag_z_d = (out_q == 16'd0);
               flag_n_d = out_q[15];
            end
            OP_MUL: begin
               flag_upd = 1'b1;
               flag_z_d = ({r_q, out_q} == 32'd0);
               flag_n_d = r_q[15];
            end
            default: begin
               flag_upd = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flag_z <= 1'b0;
         flag_n <= 1'b0;
      end else if (flag_upd) begin
         flag_z <= flag_z_d;
         flag_n <= flag_n_d;
      end
   end

   // ------------------------------------------------------------------
   // Retired-result counter, wraps naturally at 2^CNT_W.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired <= '0;
      end else if (xfer) begin
         retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_alu_writeback.sv
// ---------------------------------------------------------------------------
// tb_alu_writeback
//
// Directed bench for alu_writeback. Inputs change 1 ns after a rising edge;
// outputs are sampled at the same point, i.e. reflecting the state loaded
// by that edge. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_alu_writeback;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_op;
   logic [3:0]  in_dest;
   logic [15:0] in_out;
   logic [15:0] in_r;
   logic        in_sign;
   logic        rf_we;
   logic [3:0]  rf_waddr;
   logic [15:0] rf_wdata;
   logic        flag_z;
   logic        flag_n;
   logic [15:0] retired;

   int total;
   int bad;

   alu_writeback #(
      .REM_REG (4'd15),
      .CNT_W   (16)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_op    (in_op),
      .in_dest  (in_dest),
      .in_out   (in_out),
      .in_r     (in_r),
      .in_sign  (in_sign),
      .rf_we    (rf_we),
      .rf_waddr (rf_waddr),
      .rf_wdata (rf_wdata),
      .flag_z   (flag_z),
      .flag_n   (flag_n),
      .retired  (retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [2:0] op, input logic [3:0] dest,
                        input logic [15:0] o, input logic [15:0] r, input logic s);
      in_valid = v;
      in_op    = op;
      in_dest  = dest;
      in_out   = o;
      in_r     = r;
      in_sign  = s;
   endtask

   task automatic chk_wr(input string tag, input logic we, input logic [3:0] a, input logic [15:0] d);
      chk({tag, ".we"}, {31'd0, rf_we}, {31'd0, we});
      if (we) begin
         chk({tag, ".addr"}, {28'd0, rf_waddr}, {28'd0, a});
         chk({tag, ".data"}, {16'd0, rf_wdata}, {16'd0, d});
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      drive(1'b0, 3'd0, 4'd0, 16'd0, 16'd0, 1'b0);

      // ---------------- reset state ----------------
      tick();
      tick();
      chk("rst.ready",   {31'd0, in_ready}, 32'd1);
      chk("rst.we",      {31'd0, rf_we},    32'd0);
      chk("rst.waddr",   {28'd0, rf_waddr}, 32'd0);
      chk("rst.wdata",   {16'd0, rf_wdata}, 32'd0);
      chk("rst.z",       {31'd0, flag_z},   32'd0);
      chk("rst.n",       {31'd0, flag_n},   32'd0);
      chk("rst.retired", {16'd0, retired},  32'd0);
      rst_n = 1'b1;
      tick();

      // ---------------- back-to-back adds ----------------
      drive(1'b1, 3'b000, 4'd3, 16'h0005, 16'h0000, 1'b1);
      tick();
      chk_wr("add1", 1'b1, 4'd3, 16'h0005);
      chk("add1.ready", {31'd0, in_ready}, 32'd1);
      drive(1'b1, 3'b000, 4'd4, 16'hFFFF, 16'h0000, 1'b1);
      tick();
      chk_wr("add2", 1'b1, 4'd4, 16'hFFFF);
      chk("add2.ready", {31'd0, in_ready}, 32'd1);
      drive(1'b0, 3'd0, 4'd0, 16'd0, 16'd0, 1'b0);
      tick();
      chk_wr("add.idle", 1'b0, 4'd0, 16'd0);
      chk("add.n",       {31'd0, flag_n},  32'd1);
      chk("add.z",       {31'd0, flag_z},  32'd0);
      chk("add.retired", {16'd0, retired}, 32'd2);

      // ---------------- multiply, valid held across the stall ----------------
      drive(1'b1, 3'b010, 4'd2, 16'h0000, 16'h0001, 1'b1);
      tick();
      chk_wr("mul.lo", 1'b1, 4'd2, 16'h0000);
      chk("mul.lo.ready", {31'd0, in_ready}, 32'd0);
      tick();
      chk_wr("mul.hi", 1'b1, 4'd15, 16'h0001);
      chk("mul.hi.ready", {31'd0, in_ready}, 32'd1);
      chk("mul.z", {31'd0, flag_z}, 32'd0);
      chk("mul.n", {31'd0, flag_n}, 32'd0);
      drive(1'b0, 3'd0, 4'd0, 16'd0, 16'd0, 1'b0);
      tick();
      chk_wr("mul.idle", 1'b0, 4'd0, 16'd0);
      chk("mul.retired", {16'd0, retired}, 32'd3);

      // ---------------- divide followed by AND accepted in WB_HI ----------------
      drive(1'b1, 3'b011, 4'd5, 16'h0003, 16'h0002, 1'b1);
      tick();
      chk_wr("div.lo", 1'b1, 4'd5, 16'h0003);
      chk("div.lo.ready", {31'd0, in_ready}, 32'd0);
      drive(1'b1, 3'b100, 4'd6, 16'h00F0, 16'h0000, 1'b0);
      tick();
      chk_wr("div.hi", 1'b1, 4'd15, 16'h0002);
      chk("div.hi.ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk_wr("and", 1'b1, 4'd6, 16'h00F0);
      drive(1'b0, 3'd0, 4'd0, 16'd0, 16'd0, 1'b0);
      tick();
      chk_wr("and.idle", 1'b0, 4'd0, 16'd0);
      chk("div.retired", {16'd0, retired}, 32'd5);
      chk("div.z", {31'd0, flag_z}, 32'd0);

      // ---------------- suppressed writes ----------------
      drive(1'b1, 3'b111, 4'd7, 16'h0000, 16'h0000, 1'b1);
      tick();
      chk("nowb.we", {31'd0, rf_we}, 32'd0);
      drive(1'b1, 3'b000, 4'd0, 16'h0000, 16'h0000, 1'b0);
      tick();
      chk("r0.we", {31'd0, rf_we}, 32'd0);
      chk("r0.ready", {31'd0, in_ready}, 32'd1);
      drive(1'b0, 3'd0, 4'd0, 16'd0, 16'd0, 1'b0);
      tick();
      chk("sup.retired", {16'd0, retired}, 32'd7);
      chk("sup.z", {31'd0, flag_z}, 32'd0);
      chk("sup.n", {31'd0, flag_n}, 32'd0);

      // ---------------- unsigned op leaves flags alone ----------------
      drive(1'b1, 3'b101, 4'd8, 16'h0000, 16'h0000, 1'b1);
      tick();
      chk_wr("uns", 1'b1, 4'd8, 16'h0000);
      drive(1'b0, 3'd0, 4'd0, 16'd0, 16'd0, 1'b0);
      tick();
      chk("uns.z", {31'd0, flag_z}, 32'd0);
      chk("uns.retired", {16'd0, retired}, 32'd8);

      // ---------------- reset during WB_HI aborts the R write ----------------
      drive(1'b1, 3'b010, 4'd9, 16'h1111, 16'h2222, 1'b1);
      tick();
      chk_wr("rmul.lo", 1'b1, 4'd9, 16'h1111);
      drive(1'b0, 3'd0, 4'd0, 16'd0, 16'd0, 1'b0);
      tick();
      chk_wr("rmul.hi", 1'b1, 4'd15, 16'h2222);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst2.we",      {31'd0, rf_we},    32'd0);
      chk("rst2.ready",   {31'd0, in_ready}, 32'd1);
      chk("rst2.retired", {16'd0, retired},  32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("rst2.after.we",      {31'd0, rf_we},    32'd0);
      chk("rst2.after.ready",   {31'd0, in_ready}, 32'd1);
      chk("rst2.after.z",       {31'd0, flag_z},   32'd0);
      chk("rst2.after.n",       {31'd0, flag_n},   32'd0);
      chk("rst2.after.retired", {16'd0, retired},  32'd0);
      tick();
      chk("rst2.after2.we", {31'd0, rf_we}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
